// File: rtl/part_seq_ctrl_if.sv
// Command, scan-stream, part-pin and status bundle for part_seq_ctrl.
// master = command processor / part side, slave = the sequencer.
interface part_seq_ctrl_if #(parameter int CNT_W = 16);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic             pause;
  logic             scan_in_valid;
  logic             scan_in_bit;
  logic             scan_in_ready;
  logic             scan_out_valid;
  logic             scan_out_bit;
  logic             scan_out_ready;
  logic             part_clk;
  logic             part_test_se;
  logic             part_test_tm;
  logic             part_scan_in;
  logic             part_scan_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cycles_run;

  modport master (
    output cmd_valid, cmd_op, cmd_count, pause, scan_in_valid, scan_in_bit,
           scan_out_ready, part_scan_out,
    input  cmd_ready, scan_in_ready, scan_out_valid, scan_out_bit, part_clk,
           part_test_se, part_test_tm, part_scan_in, busy, done, cycles_run
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, pause, scan_in_valid, scan_in_bit,
           scan_out_ready, part_scan_out,
    output cmd_ready, scan_in_ready, scan_out_valid, scan_out_bit, part_clk,
           part_test_se, part_test_tm, part_scan_in, busy, done, cycles_run
  );
endinterface

// File: rtl/part_seq_ctrl.sv
// Part sequencer: gated part clock for EXEC/FREE runs and bit-serial
// scan-chain transfers. Every output is a register, so part_clk is glitch-free.
module part_seq_ctrl #(
  parameter int HALF_PERIOD = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rstn,
  part_seq_ctrl_if.slave   bus
);
  localparam int PH_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_SCAN_SETUP, S_SCAN_OUT, S_SCAN_IN, S_SCAN_LO, S_SCAN_HI, S_FINISH
  } state_t;

  state_t           r_state;
  logic             r_free;      // FREE run (stop on pause) vs EXEC (stop on count)
  logic             r_stop;      // pause seen mid-cycle; finish after this cycle
  logic [CNT_W-1:0] r_rem;       // part cycles / scan bits still to do
  logic [PH_W-1:0]  r_ph;        // clocks spent in the current part_clk phase
  logic             r_part_clk;
  logic             r_se;        // drives both test_se and test_tm
  logic             r_scan_in;
  logic             r_so_valid;
  logic             r_so_bit;
  logic             r_si_ready;
  logic             r_cmd_ready;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_cycles;

  logic w_ph_end;
  logic w_cyc_max;
  logic w_run_stop;

  assign w_ph_end   = (r_ph == PH_LAST);
  assign w_cyc_max  = &r_cycles;
  // A run may only end at a cycle boundary: part_clk low with no phase elapsed.
  assign w_run_stop = r_free ? (r_stop || bus.pause) : (r_rem == '0);

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_free      <= 1'b0;
      r_stop      <= 1'b0;
      r_rem       <= '0;
      r_ph        <= '0;
      r_part_clk  <= 1'b0;
      r_se        <= 1'b0;
      r_scan_in   <= 1'b0;
      r_so_valid  <= 1'b0;
      r_so_bit    <= 1'b0;
      r_si_ready  <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cycles    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          r_part_clk  <= 1'b0;
          if (bus.cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_ph        <= '0;
            r_stop      <= 1'b0;
            case (bus.cmd_op)
              2'b10: begin
                r_state <= S_SCAN_SETUP;
                r_se    <= 1'b1;
                r_rem   <= bus.cmd_count;
              end
              2'b01: begin
                r_state  <= S_RUN;
                r_free   <= 1'b1;
                r_rem    <= '0;
                r_cycles <= '0;
              end
              2'b00: begin
                r_state  <= S_RUN;
                r_free   <= 1'b0;
                r_rem    <= bus.cmd_count;
                r_cycles <= '0;
              end
              default: begin            // reserved op runs as EXEC of 0 cycles
                r_state  <= S_RUN;
                r_free   <= 1'b0;
                r_rem    <= '0;
                r_cycles <= '0;
              end
            endcase
          end
        end
        S_RUN: begin
          if (r_free && bus.pause) r_stop <= 1'b1;
          if (!r_part_clk) begin
            if (r_ph == '0 && w_run_stop) begin
              r_state <= S_FINISH;
            end else if (w_ph_end) begin
              r_part_clk <= 1'b1;
              r_ph       <= '0;
            end else begin
              r_ph <= r_ph + 1'b1;
            end
          end else if (w_ph_end) begin
            // high->low return completes the cycle
            r_part_clk <= 1'b0;
            r_ph       <= '0;
            if (!r_free)    r_rem    <= r_rem - 1'b1;
            if (!w_cyc_max) r_cycles <= r_cycles + 1'b1;
          end else begin
            r_ph <= r_ph + 1'b1;
          end
        end
        S_SCAN_SETUP: begin
          if (w_ph_end) begin
            r_ph <= '0;
            if (r_rem == '0) begin
              r_state <= S_FINISH;
              r_se    <= 1'b0;
            end else begin
              r_state    <= S_SCAN_OUT;
              r_so_bit   <= bus.part_scan_out;
              r_so_valid <= 1'b1;
            end
          end else begin
            r_ph <= r_ph + 1'b1;
          end
        end
        S_SCAN_OUT: begin
          if (r_so_valid && bus.scan_out_ready) begin
            r_so_valid <= 1'b0;
            r_si_ready <= 1'b1;
            r_state    <= S_SCAN_IN;
          end
        end
        S_SCAN_IN: begin
          if (bus.scan_in_valid && r_si_ready) begin
            r_scan_in  <= bus.scan_in_bit;
            r_si_ready <= 1'b0;
            r_ph       <= '0;
            r_state    <= S_SCAN_LO;
          end
        end
        S_SCAN_LO: begin
          if (w_ph_end) begin
            r_part_clk <= 1'b1;
            r_ph       <= '0;
            r_state    <= S_SCAN_HI;
          end else begin
            r_ph <= r_ph + 1'b1;
          end
        end
        S_SCAN_HI: begin
          if (w_ph_end) begin
            r_part_clk <= 1'b0;
            r_ph       <= '0;
            r_rem      <= r_rem - 1'b1;
            if (r_rem == CNT_W'(1)) begin
              r_state <= S_FINISH;
              r_se    <= 1'b0;
            end else begin
              // chain has shifted on the rising edge; capture the next bit
              r_state    <= S_SCAN_OUT;
              r_so_bit   <= bus.part_scan_out;
              r_so_valid <= 1'b1;
            end
          end else begin
            r_ph <= r_ph + 1'b1;
          end
        end
        S_FINISH: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
          r_cmd_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready      = r_cmd_ready;
  assign bus.scan_in_ready  = r_si_ready;
  assign bus.scan_out_valid = r_so_valid;
  assign bus.scan_out_bit   = r_so_bit;
  assign bus.part_clk       = r_part_clk;
  assign bus.part_test_se   = r_se;
  assign bus.part_test_tm   = r_se;
  assign bus.part_scan_in   = r_scan_in;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.cycles_run     = r_cycles;
endmodule

// File: tb/tb_part_seq_ctrl.sv
// Directed bench for part_seq_ctrl with a 4-bit scan-chain part model and a
// scoreboard of per-command expectations popped when done pulses.
module tb_part_seq_ctrl;
  localparam int HP = 4;
  localparam int CW = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  part_seq_ctrl_if #(.CNT_W(CW)) bus();

  part_seq_ctrl #(.HALF_PERIOD(HP), .CNT_W(CW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #10 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, n_rise = 0, n_se_clk = 0;
  int t_acc = 0, rise0 = 0;

  // part model: chain shifts toward bit 0 on part_clk rise in scan mode
  logic [3:0] chain = 4'b1011;
  assign bus.part_scan_out = chain[0];
  always @(posedge bus.part_clk)
    if (bus.part_test_se && bus.part_test_tm) chain <= {bus.part_scan_in, chain[3:1]};

  always @(posedge clk) cyc++;
  always @(posedge bus.part_clk) n_rise++;
  always @(posedge clk) if (bus.part_test_se) n_se_clk++;

  typedef struct { int lat; int cyc_run; int rises; } exp_t;
  exp_t exp_q[$];
  logic so_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [1:0] op, input int cnt);
    int ok;
    ok = 0;
    @(negedge clk);
    bus.cmd_op    = op;
    bus.cmd_count = cnt[CW-1:0];
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (bus.cmd_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("cmd_accept", ok, 1);
    @(posedge clk); #1;
    t_acc = cyc;
    rise0 = n_rise;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin ok = 1; break; end
    end
    chk({tag, "_done"}, ok, 1);
    chk({tag, "_sb_nonempty"}, exp_q.size(), exp_q.size() > 0 ? exp_q.size() : 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.lat >= 0) chk({tag, "_latency"}, cyc - t_acc, e.lat);
      chk({tag, "_cycles_run"}, bus.cycles_run, e.cyc_run);
      chk({tag, "_rises"}, n_rise - rise0, e.rises);
    end
    chk({tag, "_clk_low"}, bus.part_clk, 0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, bus.done, 0);
  endtask

  task automatic scan_xfer(input logic inb, input int stall);
    int ok, r0;
    logic eb;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.scan_out_valid) begin ok = 1; break; end
    end
    chk("so_valid", ok, 1);
    eb = so_q.pop_front();
    chk("scan_out_bit", bus.scan_out_bit, eb);
    chk("se_tm_in_scan", {bus.part_test_se, bus.part_test_tm}, 2'b11);
    if (stall > 0) begin
      r0 = n_rise;
      repeat (stall) @(negedge clk);
      chk("stall_no_edge", n_rise - r0, 0);
      chk("stall_valid_held", bus.scan_out_valid, 1);
      chk("stall_clk_low", bus.part_clk, 0);
    end
    bus.scan_out_ready = 1'b1;
    @(posedge clk); #1;
    bus.scan_out_ready = 1'b0;
    bus.scan_in_valid  = 1'b1;
    bus.scan_in_bit    = inb;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.scan_in_ready) begin ok = 1; break; end
    end
    chk("si_ready", ok, 1);
    @(posedge clk); #1;
    bus.scan_in_valid = 1'b0;
  endtask

  initial begin
    int ok, se0;
    bus.cmd_valid      = 1'b0;
    bus.cmd_op         = 2'b00;
    bus.cmd_count      = '0;
    bus.pause          = 1'b0;
    bus.scan_in_valid  = 1'b0;
    bus.scan_in_bit    = 1'b0;
    bus.scan_out_ready = 1'b0;

    // reset state
    #5 rstn = 1'b0;
    #10;
    chk("rst_outs", {bus.cmd_ready, bus.busy, bus.done, bus.part_clk, bus.part_test_se,
                     bus.part_test_tm, bus.part_scan_in, bus.scan_out_valid, bus.scan_in_ready}, 0);
    chk("rst_cycles_run", bus.cycles_run, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst_cmd_ready", bus.cmd_ready, 1);

    // EXEC 4: 2*4*4+2 = 34 clocks, no scan enable
    se0 = n_se_clk;
    exp_q.push_back('{34, 4, 4});
    send(2'b00, 4);
    chk("exec_busy", bus.busy, 1);
    chk("exec_cmd_ready_low", bus.cmd_ready, 0);
    wait_done("exec4");
    chk("exec_no_se", n_se_clk - se0, 0);

    // EXEC 0 and reserved op: done 2 clocks after acceptance
    exp_q.push_back('{2, 0, 0});
    send(2'b00, 0);
    wait_done("exec0");
    exp_q.push_back('{2, 0, 0});
    send(2'b11, 9);
    wait_done("op11");

    // FREE, pause from clock 50 (inside cycle 7): finish at 56, done at 58
    exp_q.push_back('{58, 7, 7});
    send(2'b01, 0);
    repeat (49) @(posedge clk);
    #1 bus.pause = 1'b1;
    wait_done("free");
    bus.pause = 1'b0;

    // SCAN 4: chain 1011 -> out 1,1,0,1; shift in 0,1,1,0 -> chain 0110
    exp_q.push_back('{-1, 7, 4});
    so_q.push_back(1'b1); so_q.push_back(1'b1); so_q.push_back(1'b0); so_q.push_back(1'b1);
    send(2'b10, 4);
    scan_xfer(1'b0, 0);
    scan_xfer(1'b1, 0);
    scan_xfer(1'b1, 0);
    scan_xfer(1'b0, 0);
    wait_done("scan4");
    chk("scan4_chain", chain, 4'b0110);
    chk("scan4_se_tm_off", {bus.part_test_se, bus.part_test_tm}, 2'b00);
    chk("scan4_si_hold", bus.part_scan_in, 0);

    // SCAN 3 with a 20-clock stall on bit 2: out 0,1,1; in 1,0,1 -> chain 1010
    exp_q.push_back('{-1, 7, 3});
    so_q.push_back(1'b0); so_q.push_back(1'b1); so_q.push_back(1'b1);
    send(2'b10, 3);
    scan_xfer(1'b1, 0);
    scan_xfer(1'b0, 20);
    scan_xfer(1'b1, 0);
    wait_done("scan3");
    chk("scan3_chain", chain, 4'b1010);
    chk("scan3_si_hold", bus.part_scan_in, 1);

    // async reset during the high phase of an EXEC 10
    send(2'b00, 10);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.part_clk) begin ok = 1; break; end
    end
    chk("rst_mid_high_seen", ok, 1);
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    chk("rst_mid_outs", {bus.part_clk, bus.busy, bus.done, bus.part_test_se, bus.part_test_tm,
                         bus.cmd_ready}, 0);
    chk("rst_mid_cycles", bus.cycles_run, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst_rel_cmd_ready", bus.cmd_ready, 1);
    exp_q.push_back('{2*2*HP + 2, 2, 2});
    send(2'b00, 2);
    wait_done("exec2_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
